// File: rtl/execute_param_pkg.sv
// Shared definitions for the execute stage: opcode map, FSM encoding and branch mask layout.
// Branch opcodes are 8'b00100_nzp, so the low three bits carry the condition mask directly.
package execute_param_pkg;

   localparam int OPCODE_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MUL_BUSY = 2'd1,
      ST_HOLD     = 2'd2
   } state_e;

   localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 8'h01;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 8'h02;
   localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 8'h03;
   localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 8'h04;
   localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = 8'h05;
   localparam logic [OPCODE_WIDTH-1:0] OP_MOVI  = 8'h06;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = 8'h07;
   localparam logic [OPCODE_WIDTH-1:0] OP_STW   = 8'h08;
   localparam logic [OPCODE_WIDTH-1:0] OP_MUL   = 8'h09;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRP   = 8'h21;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRZ   = 8'h22;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRZP  = 8'h23;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRN   = 8'h24;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRNP  = 8'h25;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRNZ  = 8'h26;
   localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP = 8'h27;
   localparam logic [OPCODE_WIDTH-1:0] OP_JSR   = 8'h30;

   localparam logic [4:0] BR_PREFIX = 5'b00100;
   localparam int BR_N_BIT = 2;
   localparam int BR_Z_BIT = 1;
   localparam int BR_P_BIT = 0;

   // A zero mask under the branch prefix is not a branch.
   function automatic logic is_branch(input logic [OPCODE_WIDTH-1:0] op);
      return (op[7:3] == BR_PREFIX) && (op[2:0] != 3'b000);
   endfunction

endpackage

// File: rtl/exec_brcond.sv
// Branch-condition evaluation: compares the n/z/p mask of a branch opcode with the sign of a value.
module exec_brcond
   import execute_param_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [OPCODE_WIDTH-1:0] opcode_i,
   input  logic [WIDTH-1:0]        value_i,
   output logic                    taken_o
);

   logic neg;
   logic zero;
   logic pos;

   assign neg  = value_i[WIDTH-1];
   assign zero = (value_i == '0);
   assign pos  = !neg && !zero;

   always_comb begin
      taken_o = 1'b0;
      if (opcode_i == OP_JSR) begin
         taken_o = 1'b1;
      end else if (is_branch(opcode_i)) begin
         taken_o = (opcode_i[BR_N_BIT] & neg)
                 | (opcode_i[BR_Z_BIT] & zero)
                 | (opcode_i[BR_P_BIT] & pos);
      end
   end

endmodule

// File: rtl/execute_param.sv
// Execute stage: single-cycle ALU/branch ops, multi-cycle multiply, valid/ready on both sides.
// State updates on the falling edge of I_CLOCK; reset is synchronous to that edge.
//
//   state       | meaning
//   ST_IDLE     | accepting; output register may hold a result awaiting consumption
//   ST_MUL_BUSY | multiply in flight, counter running down to the result edge
//   ST_HOLD     | multiply result presented, waiting for downstream to take it
module execute_param
   import execute_param_pkg::*;
#(
   parameter int REG_WIDTH    = 16,
   parameter int PC_WIDTH     = 16,
   parameter int REGIDX_WIDTH = 4,
   parameter int MUL_CYCLES   = 3
) (
   input  logic                    I_CLOCK,
   input  logic                    I_RESET_N,
   input  logic                    I_Valid,
   output logic                    O_Ready,
   input  logic [PC_WIDTH-1:0]     I_PC,
   input  logic [OPCODE_WIDTH-1:0] I_Opcode,
   input  logic [REG_WIDTH-1:0]    I_Src1Value,
   input  logic [REG_WIDTH-1:0]    I_Src2Value,
   input  logic [REG_WIDTH-1:0]    I_Imm,
   input  logic [REG_WIDTH-1:0]    I_DestValue,
   input  logic [REGIDX_WIDTH-1:0] I_DestRegIdx,
   output logic                    O_Valid,
   input  logic                    I_Ready,
   output logic [REG_WIDTH-1:0]    O_ALUOut,
   output logic [REG_WIDTH-1:0]    O_DestValue,
   output logic [OPCODE_WIDTH-1:0] O_Opcode,
   output logic [REGIDX_WIDTH-1:0] O_DestRegIdx,
   output logic                    O_BrTaken
);

   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

   state_e                  state_q;
   logic [3:0]              cnt_q;
   logic [REG_WIDTH-1:0]    mul_a_q;
   logic [REG_WIDTH-1:0]    mul_b_q;
   logic [OPCODE_WIDTH-1:0] mul_opc_q;
   logic [REGIDX_WIDTH-1:0] mul_idx_q;
   logic [REG_WIDTH-1:0]    mul_dv_q;

   logic                    valid_q;
   logic [REG_WIDTH-1:0]    aluout_q;
   logic [REG_WIDTH-1:0]    destval_q;
   logic [OPCODE_WIDTH-1:0] opc_q;
   logic [REGIDX_WIDTH-1:0] idx_q;
   logic                    brtaken_q;

   logic                    accept;
   logic                    consume;
   logic                    is_mul;
   logic                    br_taken;
   logic [REG_WIDTH-1:0]    mul_a;
   logic [REG_WIDTH-1:0]    mul_b;
   logic [REG_WIDTH-1:0]    product;
   logic [PC_WIDTH-1:0]     br_target;
   logic [REG_WIDTH-1:0]    alu_res;

   assign O_Ready = (state_q == ST_IDLE) && (!valid_q || I_Ready);
   assign accept  = I_Valid && O_Ready;
   assign consume = valid_q && I_Ready;
   assign is_mul  = (I_Opcode == OP_MUL);

   // One multiplier: latched operands while busy, live operands for the single-cycle case.
   assign mul_a   = (state_q == ST_MUL_BUSY) ? mul_a_q : I_Src1Value;
   assign mul_b   = (state_q == ST_MUL_BUSY) ? mul_b_q : I_Src2Value;
   assign product = mul_a * mul_b;

   assign br_target = I_PC + PC_WIDTH'({I_Imm, 2'b00});

   exec_brcond #(
      .WIDTH (REG_WIDTH)
   ) u_brcond (
      .opcode_i (I_Opcode),
      .value_i  (I_DestValue),
      .taken_o  (br_taken)
   );

   always_comb begin
      alu_res = '0;
      case (I_Opcode)
         OP_ADD:  alu_res = I_Src1Value + I_Src2Value;
         OP_ADDI: alu_res = I_Src1Value + I_Imm;
         OP_AND:  alu_res = I_Src1Value & I_Src2Value;
         OP_ANDI: alu_res = I_Src1Value & I_Imm;
         OP_MOV:  alu_res = I_Src2Value;
         OP_MOVI: alu_res = I_Imm;
         OP_LDW:  alu_res = I_Src1Value + I_Imm;
         OP_STW:  alu_res = I_Src1Value + I_Imm;
         OP_MUL:  alu_res = product;
         OP_JSR:  alu_res = REG_WIDTH'(br_target);
         default: if (is_branch(I_Opcode)) alu_res = REG_WIDTH'(br_target);
      endcase
   end

   always_ff @(negedge I_CLOCK) begin
      if (!I_RESET_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         mul_opc_q <= '0;
         mul_idx_q <= '0;
         mul_dv_q  <= '0;
         valid_q   <= 1'b0;
         aluout_q  <= '0;
         destval_q <= '0;
         opc_q     <= '0;
         idx_q     <= '0;
         brtaken_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_mul && (MUL_CYCLES > 1)) begin
                     mul_a_q   <= I_Src1Value;
                     mul_b_q   <= I_Src2Value;
                     mul_opc_q <= I_Opcode;
                     mul_idx_q <= I_DestRegIdx;
                     mul_dv_q  <= I_DestValue;
                     cnt_q     <= MUL_LOAD;
                     valid_q   <= 1'b0;
                     state_q   <= ST_MUL_BUSY;
                  end else begin
                     valid_q   <= 1'b1;
                     aluout_q  <= alu_res;
                     destval_q <= I_DestValue;
                     opc_q     <= I_Opcode;
                     idx_q     <= I_DestRegIdx;
                     brtaken_q <= br_taken;
                  end
               end else if (consume) begin
                  valid_q <= 1'b0;
               end
            end
            ST_MUL_BUSY: begin
               // Counter at 1 means this edge is the last multiply cycle.
               if (cnt_q <= 4'd1) begin
                  cnt_q     <= '0;
                  valid_q   <= 1'b1;
                  aluout_q  <= product;
                  destval_q <= mul_dv_q;
                  opc_q     <= mul_opc_q;
                  idx_q     <= mul_idx_q;
                  brtaken_q <= 1'b0;
                  state_q   <= ST_HOLD;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_HOLD: begin
               if (consume) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign O_Valid      = valid_q;
   assign O_ALUOut     = aluout_q;
   assign O_DestValue  = destval_q;
   assign O_Opcode     = opc_q;
   assign O_DestRegIdx = idx_q;
   assign O_BrTaken    = brtaken_q;

endmodule

// File: tb/tb_execute_param.sv
// Directed bench for execute_param: reset, ALU ops, multiply latency/stall, branches, back-to-back, reset abort.
module tb_execute_param;
   import execute_param_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] i_pc;
   logic [7:0]  i_opcode;
   logic [15:0] i_src1;
   logic [15:0] i_src2;
   logic [15:0] i_imm;
   logic [15:0] i_destval;
   logic [3:0]  i_idx;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_aluout;
   logic [15:0] o_destval;
   logic [7:0]  o_opcode;
   logic [3:0]  o_idx;
   logic        o_brtaken;

   int total = 0;
   int bad   = 0;
   logic [15:0] seen_q[$];

   execute_param dut (
      .I_CLOCK      (clk),
      .I_RESET_N    (rst_n),
      .I_Valid      (i_valid),
      .O_Ready      (o_ready),
      .I_PC         (i_pc),
      .I_Opcode     (i_opcode),
      .I_Src1Value  (i_src1),
      .I_Src2Value  (i_src2),
      .I_Imm        (i_imm),
      .I_DestValue  (i_destval),
      .I_DestRegIdx (i_idx),
      .O_Valid      (o_valid),
      .I_Ready      (i_ready),
      .O_ALUOut     (o_aluout),
      .O_DestValue  (o_destval),
      .O_Opcode     (o_opcode),
      .O_DestRegIdx (o_idx),
      .O_BrTaken    (o_brtaken)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // DUT updates on the falling edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic tick_rec();
      if (o_valid && i_ready) seen_q.push_back(o_aluout);
      tick();
   endtask

   task automatic issue(input logic [7:0] op, input logic [15:0] s1, input logic [15:0] s2,
                        input logic [15:0] imm, input logic [15:0] dv, input logic [3:0] idx,
                        input logic [15:0] pc);
      i_valid   = 1'b1;
      i_opcode  = op;
      i_src1    = s1;
      i_src2    = s2;
      i_imm     = imm;
      i_destval = dv;
      i_idx     = idx;
      i_pc      = pc;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
      i_pc = '0; i_opcode = '0; i_src1 = '0; i_src2 = '0; i_imm = '0; i_destval = '0; i_idx = '0;
      tick(); tick();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", o_valid); end
      total++; if ({o_aluout, o_destval, o_opcode, o_idx, o_brtaken} !== '0) begin
         bad++; $display("FAIL rst_outs got=%h/%h/%h/%h/%b want=all zero", o_aluout, o_destval, o_opcode, o_idx, o_brtaken);
      end
      rst_n = 1'b1; i_ready = 1'b1;
      tick();
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", o_ready); end
   endtask

   task automatic test_add();
      issue(OP_ADD, 16'hFFFF, 16'h0002, 16'h0000, 16'hABCD, 4'd2, 16'h0);
      tick();
      total++; if (o_valid !== 1'b1 || o_aluout !== 16'h0001) begin
         bad++; $display("FAIL add_wrap got=%b/%h want=1/0001", o_valid, o_aluout);
      end
      total++; if (o_opcode !== OP_ADD || o_idx !== 4'd2 || o_destval !== 16'hABCD) begin
         bad++; $display("FAIL add_side got=%h/%h/%h want=01/2/abcd", o_opcode, o_idx, o_destval);
      end
      i_valid = 1'b0;
      tick();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL add_clear got=%b want=0", o_valid); end
   endtask

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] s1;
      logic [15:0] s2;
      logic [15:0] imm;
      logic [15:0] exp;
   } alu_vec_t;

   task automatic test_alu_ops();
      alu_vec_t v[7];
      v[0] = '{OP_ADDI, 16'h1234, 16'h5555, 16'h0F0F, 16'h2143};
      v[1] = '{OP_AND,  16'hF0F0, 16'h3C3C, 16'hFFFF, 16'h3030};
      v[2] = '{OP_ANDI, 16'hFF00, 16'h0000, 16'h0FF0, 16'h0F00};
      v[3] = '{OP_MOV,  16'h1111, 16'hBEEF, 16'h2222, 16'hBEEF};
      v[4] = '{OP_MOVI, 16'h1111, 16'h3333, 16'h00A5, 16'h00A5};
      v[5] = '{OP_LDW,  16'hFFF0, 16'h7777, 16'h0020, 16'h0010};
      v[6] = '{OP_STW,  16'h1000, 16'h8888, 16'h0004, 16'h1004};
      for (int i = 0; i < 7; i++) begin
         issue(v[i].op, v[i].s1, v[i].s2, v[i].imm, 16'h8000, 4'(i), 16'h0040);
         tick();
         total++; if (o_valid !== 1'b1 || o_aluout !== v[i].exp || o_brtaken !== 1'b0 || o_opcode !== v[i].op) begin
            bad++; $display("FAIL alu_%0d got=%b/%h/%b/%h want=1/%h/0/%h", i, o_valid, o_aluout, o_brtaken, o_opcode, v[i].exp, v[i].op);
         end
      end
      i_valid = 1'b0;
      tick();
   endtask

   task automatic test_mul();
      issue(OP_MUL, 16'd300, 16'd300, 16'h0000, 16'h1111, 4'd3, 16'h0);
      tick();
      i_valid = 1'b0; i_src1 = 16'h7777; i_src2 = 16'h9999; i_destval = 16'h0; i_idx = 4'd0;
      #1;
      for (int i = 0; i < 2; i++) begin
         total++; if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
            bad++; $display("FAIL mul_busy_%0d got ready=%b valid=%b want 0/0", i, o_ready, o_valid);
         end
         if (i == 0) tick();
      end
      i_ready = 1'b0;
      tick();
      total++; if (o_valid !== 1'b1 || o_aluout !== 16'h5F90) begin
         bad++; $display("FAIL mul_result got=%b/%h want=1/5f90", o_valid, o_aluout);
      end
      total++; if (o_opcode !== OP_MUL || o_idx !== 4'd3 || o_destval !== 16'h1111 || o_brtaken !== 1'b0) begin
         bad++; $display("FAIL mul_side got=%h/%h/%h/%b want=09/3/1111/0", o_opcode, o_idx, o_destval, o_brtaken);
      end
      tick(); tick();
      total++; if (o_valid !== 1'b1 || o_aluout !== 16'h5F90 || o_ready !== 1'b0) begin
         bad++; $display("FAIL mul_hold got=%b/%h ready=%b want=1/5f90 ready=0", o_valid, o_aluout, o_ready);
      end
      i_ready = 1'b1;
      #1;
      total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL mul_hold_ready got=%b want=0", o_ready); end
      tick();
      total++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         bad++; $display("FAIL mul_release got valid=%b ready=%b want 0/1", o_valid, o_ready);
      end
   endtask

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] pc;
      logic [15:0] imm;
      logic [15:0] dv;
      logic [15:0] exp;
      logic        tk;
   } br_vec_t;

   task automatic test_branch();
      br_vec_t v[8];
      v[0] = '{OP_BRZ,   16'h0010, 16'hFFFF, 16'h0000, 16'h000C, 1'b1};
      v[1] = '{OP_BRZ,   16'h0010, 16'hFFFF, 16'h0005, 16'h000C, 1'b0};
      v[2] = '{OP_BRN,   16'h0100, 16'h0001, 16'h8000, 16'h0104, 1'b1};
      v[3] = '{OP_BRP,   16'h0100, 16'h0001, 16'h0000, 16'h0104, 1'b0};
      v[4] = '{OP_BRNP,  16'h0200, 16'h0010, 16'h8001, 16'h0240, 1'b1};
      v[5] = '{OP_JSR,   16'h0100, 16'h0003, 16'h0000, 16'h010C, 1'b1};
      v[6] = '{OP_BRNZP, 16'hFFF0, 16'h0004, 16'h1234, 16'h0000, 1'b1};
      v[7] = '{OP_BRZP,  16'h0000, 16'h4000, 16'hFFFF, 16'h0000, 1'b0};
      for (int i = 0; i < 8; i++) begin
         issue(v[i].op, 16'h5A5A, 16'hA5A5, v[i].imm, v[i].dv, 4'd1, v[i].pc);
         tick();
         total++; if (o_valid !== 1'b1 || o_aluout !== v[i].exp || o_brtaken !== v[i].tk) begin
            bad++; $display("FAIL br_%0d got=%b/%h/%b want=1/%h/%b", i, o_valid, o_aluout, o_brtaken, v[i].exp, v[i].tk);
         end
      end
      i_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      seen_q.delete();
      i_ready = 1'b0;
      issue(OP_ADDI, 16'h0001, 16'h0, 16'h0010, 16'h0, 4'd4, 16'h0);
      tick_rec();
      issue(OP_ADDI, 16'h0100, 16'h0, 16'h0020, 16'h0, 4'd5, 16'h0);
      for (int i = 0; i < 4; i++) begin
         total++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_aluout !== 16'h0011) begin
            bad++; $display("FAIL b2b_stall_%0d got ready=%b valid=%b out=%h want 0/1/0011", i, o_ready, o_valid, o_aluout);
         end
         tick_rec();
      end
      i_ready = 1'b1;
      #1;
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", o_ready); end
      tick_rec();
      issue(OP_ADDI, 16'h1000, 16'h0, 16'h0300, 16'h0, 4'd6, 16'h0);
      tick_rec();
      i_valid = 1'b0;
      tick_rec();
      tick_rec();
      total++; if (seen_q.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", seen_q.size()); end
      else begin
         total++; if (seen_q[0] !== 16'h0011 || seen_q[1] !== 16'h0120 || seen_q[2] !== 16'h1300) begin
            bad++; $display("FAIL b2b_order got=%h,%h,%h want=0011,0120,1300", seen_q[0], seen_q[1], seen_q[2]);
         end
      end
   endtask

   task automatic test_reset_mid_mul();
      int late_valid = 0;
      issue(OP_MUL, 16'd7, 16'd9, 16'h0, 16'h0, 4'd8, 16'h0);
      tick();
      i_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      total++; if (o_valid !== 1'b0 || o_aluout !== 16'h0 || o_ready !== 1'b1) begin
         bad++; $display("FAIL rmul_reset got valid=%b out=%h ready=%b want 0/0000/1", o_valid, o_aluout, o_ready);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (o_valid !== 1'b0) late_valid++;
      end
      total++; if (late_valid != 0 || o_ready !== 1'b1) begin
         bad++; $display("FAIL rmul_ghost got valid_cycles=%0d ready=%b want 0/1", late_valid, o_ready);
      end
   endtask

   task automatic test_unknown();
      issue(8'hEE, 16'h1234, 16'h4321, 16'h00FF, 16'h8000, 4'd7, 16'h0050);
      tick();
      total++; if (o_valid !== 1'b1 || o_aluout !== 16'h0 || o_idx !== 4'd7 || o_brtaken !== 1'b0 || o_opcode !== 8'hEE) begin
         bad++; $display("FAIL unknown got=%b/%h/%h/%b/%h want=1/0000/7/0/ee", o_valid, o_aluout, o_idx, o_brtaken, o_opcode);
      end
      i_valid = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu_ops();
      test_mul();
      test_branch();
      test_back_to_back();
      test_reset_mid_mul();
      test_unknown();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/execute_param.md
EXECUTE_PARAM -- requirements
Module: execute_param

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 16, datapath width.
REQ-002 SHALL have parameter PC_WIDTH, default 16, PC width.
REQ-003 SHALL have parameter REGIDX_WIDTH, default 4, register-index width.
REQ-004 SHALL have parameter MUL_CYCLES, default 3, multiply latency in cycles; legal range 1..15.
REQ-005 SHALL have one clock and a synchronous, active-low reset.
REQ-006 SHALL have port I_CLOCK  in  1  clock; all state updates on negedge.
REQ-007 SHALL have port I_RESET_N  in  1  synchronous active-low reset.
REQ-008 SHALL have ports I_Valid  in  1 and O_Ready  out  1: upstream handshake.
REQ-009 SHALL have ports I_PC  in  PC_WIDTH; I_Opcode  in  OPCODE_WIDTH; I_Src1Value, I_Src2Value, I_Imm, I_DestValue  in  REG_WIDTH; I_DestRegIdx  in  REGIDX_WIDTH.
REQ-010 SHALL have ports O_Valid  out  1 and I_Ready  in  1: downstream handshake.
REQ-011 SHALL have ports O_ALUOut, O_DestValue  out  REG_WIDTH; O_Opcode  out  OPCODE_WIDTH; O_DestRegIdx  out  REGIDX_WIDTH; O_BrTaken  out  1.

Function
REQ-012 SHALL accept an input when I_Valid and O_Ready are high on the same clock edge.
REQ-013 SHALL present a result when O_Valid is high; it is consumed when O_Valid and I_Ready are both high.
REQ-014 SHALL drive O_Ready = (state IDLE) and (!O_Valid or I_Ready), combinationally.
REQ-015 SHALL use three FSM states: IDLE, MUL_BUSY and HOLD.
REQ-016 IDLE + accepted non-MUL op SHALL register its result next edge with O_Valid=1, and remain in IDLE (1-cycle latency).
REQ-017 IDLE + accepted MUL op SHALL latch the operands, load counter with MUL_CYCLES-1 and go to MUL_BUSY; if MUL_CYCLES=1 it SHALL instead behave as REQ-016.
REQ-018 In MUL_BUSY the counter SHALL decrement each cycle; at 0 the result registers with O_Valid=1 and the state goes to HOLD.
REQ-019 HOLD SHALL return to IDLE on the edge the output is consumed.
REQ-020 Output registers SHALL hold their values while O_Valid=1 and I_Ready=0, with no loss and no duplication.
REQ-021 O_Valid SHALL clear when the output is consumed and no new result is registered on the same edge.
REQ-022 ADD/ADDI/AND/ANDI results SHALL be Src1 op Src2 and Src1 op Imm respectively, truncated to REG_WIDTH; carry is discarded.
REQ-023 MOV SHALL output Src2; MOVI SHALL output Imm; LDW/STW SHALL output Src1+Imm (mod 2^REG_WIDTH).
REQ-024 MUL SHALL output the low REG_WIDTH bits of Src1*Src2 (unsigned).
REQ-025 BRx/JSR SHALL output I_PC + (Imm<<2), with the shift applied before the add, truncated to PC_WIDTH and zero-extended to REG_WIDTH.
REQ-026 Each BRx SHALL set O_BrTaken when its n/z/p mask matches the sign of I_DestValue (n: MSB=1; z: ==0; p: MSB=0 and !=0); JSR SHALL always set O_BrTaken=1.
REQ-027 O_BrTaken SHALL be 0 for non-branch ops.
REQ-028 An unknown opcode SHALL pass through with O_ALUOut=0.
REQ-029 O_Opcode, O_DestRegIdx and O_DestValue SHALL be registered alongside the result of the same instruction.

Reset
REQ-030 When I_RESET_N=0 at a clock edge, the FSM SHALL go to IDLE, O_Valid=0, the counter=0, and O_ALUOut, O_DestValue, O_Opcode, O_DestRegIdx and O_BrTaken SHALL all be 0.
REQ-031 Reset SHALL override any in-flight multiply or held output, with no result emitted.
REQ-032 O_Ready SHALL be 1 on the first edge after reset deasserts.

Structure
REQ-033 The opcode constants, the FSM state encoding and the branch n/z/p mask positions SHALL live in the shared global-definitions package.
REQ-034 The branch-condition evaluation SHALL be one sub-module, exec_brcond (opcode, value -> taken).
REQ-035 The multiplier SHALL be inferred in-line; there SHALL be no other sub-modules.

Verification
REQ-036 ADD, Src1=16'hFFFF, Src2=16'h0002, I_Ready=1 -> one cycle later O_Valid=1 and O_ALUOut=16'h0001.
REQ-037 MUL, Src1=300, Src2=300, MUL_CYCLES=3 -> O_Ready=0 for 2 cycles, then O_ALUOut=16'h5F90 (90000 mod 65536) and O_Valid=1.
REQ-038 BRZ, PC=16'h0010, Imm=16'hFFFF, DestValue=0 -> O_ALUOut=16'h000C and O_BrTaken=1; the same with DestValue=5 -> O_BrTaken=0.
REQ-039 Three back-to-back ADDIs with I_Ready held low 4 cycles after the first -> outputs appear in order, each exactly once, with O_Ready=0 during the stall.
REQ-040 Reset asserted in mid-MUL (counter=1) -> next edge O_Valid=0 and state IDLE; no MUL result ever appears.
REQ-041 Unknown opcode 8'hEE with DestRegIdx=7 -> O_ALUOut=0, O_DestRegIdx=7 and O_BrTaken=0.
